// File: rtl/feature_pkg.sv
// Shared types and default widths for the feature frame packer.
package feature_pkg;

  localparam int IND_WIDTH = 12;
  localparam int BW        = 8;
  localparam int DW        = 128;

  typedef enum logic {
    KEEP_FIRST     = 1'b0,
    KEEP_STRONGEST = 1'b1
  } sel_mode_e;

  typedef struct packed {
    logic [IND_WIDTH-1:0] x;
    logic [IND_WIDTH-1:0] y;
    logic [BW-1:0]        strength;
    logic [DW-1:0]        desc;
  } feature_t;

endpackage

// File: rtl/feature_argmin.sv
// Combinational min-strength / min-index reduction tree over N entries.
// Ties resolve to the lowest index.
module feature_argmin
  import feature_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = BW,
  parameter int IW = $clog2(N)
) (
  input  logic [SW-1:0] str_i [N],
  output logic [SW-1:0] min_str_o,
  output logic [IW-1:0] min_idx_o
);

  localparam int P = 1 << $clog2(N);

  // heap layout: node n has children 2n and 2n+1, leaves start at P
  logic [SW-1:0] ts [1:2*P-1];
  logic [IW-1:0] ti [1:2*P-1];

  always_comb begin
    for (int i = 0; i < P; i++) begin
      ts[P+i] = '1;
      ti[P+i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      ts[P+i] = str_i[i];
      ti[P+i] = IW'(i);
    end
    for (int n = P - 1; n >= 1; n--) begin
      if (ts[2*n+1] < ts[2*n]) begin
        ts[n] = ts[2*n+1];
        ti[n] = ti[2*n+1];
      end else begin
        ts[n] = ts[2*n];
        ti[n] = ti[2*n];
      end
    end
  end

  assign min_str_o = ts[1];
  assign min_idx_o = ti[1];

endmodule

// File: rtl/feature_frame_packer.sv
// Ping-pong per-frame feature buffer with selection policy and framed valid/ready drain.
//   state | meaning
//   IDLE  | nothing to drain; a boundary swaps banks immediately
//   SEND  | draining the read bank; a boundary swaps only on the final handshake
module feature_frame_packer
  import feature_pkg::sel_mode_e, feature_pkg::KEEP_STRONGEST;
#(
  parameter int        IND_WIDTH = feature_pkg::IND_WIDTH,
  parameter int        BW        = feature_pkg::BW,
  parameter int        DW        = feature_pkg::DW,
  parameter int        MAX_FEAT  = 32,
  parameter int        FCW       = 10,
  parameter sel_mode_e MODE      = KEEP_STRONGEST,
  localparam int       CW        = $clog2(MAX_FEAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_frame,
  input  logic                 in_valid,
  input  logic [IND_WIDTH-1:0] in_x,
  input  logic [IND_WIDTH-1:0] in_y,
  input  logic [BW-1:0]        in_strength,
  input  logic [DW-1:0]        in_desc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [IND_WIDTH-1:0] out_x,
  output logic [IND_WIDTH-1:0] out_y,
  output logic [BW-1:0]        out_strength,
  output logic [DW-1:0]        out_desc,
  output logic [FCW-1:0]       out_frame,
  output logic [CW-1:0]        out_count,
  output logic [15:0]          out_dropped,
  output logic [7:0]           overrun_cnt
);

  localparam int IW = $clog2(MAX_FEAT);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q;
  logic                 synced_q, wr_bank_q;
  logic [CW-1:0]        cnt_q [2];
  logic [15:0]          drop_q [2];
  logic [IW-1:0]        rd_idx_q;
  logic [FCW-1:0]       frame_q;
  logic [IND_WIDTH-1:0] x_q [2][MAX_FEAT];
  logic [IND_WIDTH-1:0] y_q [2][MAX_FEAT];
  logic [BW-1:0]        str_q [2][MAX_FEAT];
  logic [DW-1:0]        desc_q [2][MAX_FEAT];

  logic                 valid_q, first_q, last_q;
  logic [IND_WIDTH-1:0] ox_q, oy_q;
  logic [BW-1:0]        ostr_q;
  logic [DW-1:0]        odesc_q;
  logic [FCW-1:0]       oframe_q;
  logic [CW-1:0]        ocount_q;
  logic [15:0]          odrop_q;
  logic [7:0]           overrun_q;

  logic          hs, final_hs, swap, overrun, nb, rd_bank, full, we;
  logic [IW-1:0] widx, min_idx;
  logic [BW-1:0] min_str;
  logic [BW-1:0] bank_str [MAX_FEAT];

  always_comb begin
    for (int i = 0; i < MAX_FEAT; i++) bank_str[i] = str_q[wr_bank_q][i];
  end

  feature_argmin #(.N(MAX_FEAT), .SW(BW), .IW(IW)) u_argmin (
    .str_i     (bank_str),
    .min_str_o (min_str),
    .min_idx_o (min_idx)
  );

  always_comb begin
    hs       = valid_q && out_ready;
    final_hs = hs && last_q;
    swap     = synced_q && new_frame && (state_q == IDLE || final_hs);
    overrun  = synced_q && new_frame && !swap;
    nb       = swap ? ~wr_bank_q : wr_bank_q;
    rd_bank  = ~wr_bank_q;
    full     = (cnt_q[wr_bank_q] == CW'(MAX_FEAT));
    we       = 1'b0;
    widx     = '0;
    // a feature arriving with the boundary opens the new collect bank at slot 0
    if (new_frame) begin
      we = in_valid;
    end else if (synced_q && in_valid) begin
      if (!full) begin
        we   = 1'b1;
        widx = cnt_q[wr_bank_q][IW-1:0];
      end else if (MODE == KEEP_STRONGEST && in_strength > min_str) begin
        we   = 1'b1;
        widx = min_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      x_q[nb][widx]    <= in_x;
      y_q[nb][widx]    <= in_y;
      str_q[nb][widx]  <= in_strength;
      desc_q[nb][widx] <= in_desc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      synced_q  <= 1'b0;
      wr_bank_q <= 1'b0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      drop_q[0] <= '0;
      drop_q[1] <= '0;
      rd_idx_q  <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      ox_q      <= '0;
      oy_q      <= '0;
      ostr_q    <= '0;
      odesc_q   <= '0;
      oframe_q  <= '0;
      ocount_q  <= '0;
      odrop_q   <= '0;
      overrun_q <= '0;
    end else begin
      if (new_frame) begin
        synced_q     <= 1'b1;
        cnt_q[nb]    <= in_valid ? CW'(1) : '0;
        drop_q[nb]   <= '0;
      end else if (synced_q && in_valid) begin
        if (!full)
          cnt_q[wr_bank_q] <= cnt_q[wr_bank_q] + CW'(1);
        else if (drop_q[wr_bank_q] != '1)
          drop_q[wr_bank_q] <= drop_q[wr_bank_q] + 16'd1;
      end

      if (synced_q && new_frame) frame_q <= frame_q + FCW'(1);
      if (overrun && overrun_q != '1) overrun_q <= overrun_q + 8'd1;

      if (state_q == SEND) begin
        if (!valid_q || (hs && !last_q)) begin
          valid_q  <= 1'b1;
          first_q  <= (rd_idx_q == '0);
          last_q   <= (CW'(rd_idx_q) + CW'(1) == ocount_q);
          ox_q     <= x_q[rd_bank][rd_idx_q];
          oy_q     <= y_q[rd_bank][rd_idx_q];
          ostr_q   <= str_q[rd_bank][rd_idx_q];
          odesc_q  <= desc_q[rd_bank][rd_idx_q];
          rd_idx_q <= rd_idx_q + IW'(1);
        end else if (final_hs) begin
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      end

      // placed last so a swap on the final handshake overrides the IDLE return
      if (swap) begin
        wr_bank_q <= ~wr_bank_q;
        oframe_q  <= frame_q;
        ocount_q  <= cnt_q[wr_bank_q];
        odrop_q   <= drop_q[wr_bank_q];
        rd_idx_q  <= '0;
        state_q   <= (cnt_q[wr_bank_q] != '0) ? SEND : IDLE;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_first    = first_q;
  assign out_last     = last_q;
  assign out_x        = ox_q;
  assign out_y        = oy_q;
  assign out_strength = ostr_q;
  assign out_desc     = odesc_q;
  assign out_frame    = oframe_q;
  assign out_count    = ocount_q;
  assign out_dropped  = odrop_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_feature_frame_packer.sv
// Directed bench for feature_frame_packer with MAX_FEAT=4 in strongest-keep mode.
module tb_feature_frame_packer;
  import feature_pkg::*;

  localparam int MAXF = 4;
  localparam int CW   = $clog2(MAXF + 1);
  localparam int FCW  = 10;

  typedef struct {
    int n_in;
    int s_in [9];
    int n_exp;
    int s_exp [4];
    int x_exp [4];
    int drop;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 new_frame = 1'b0;
  logic                 in_valid = 1'b0;
  logic [IND_WIDTH-1:0] in_x = '0, in_y = '0;
  logic [BW-1:0]        in_strength = '0;
  logic [DW-1:0]        in_desc = '0;
  logic                 out_ready = 1'b0;
  logic                 out_valid, out_first, out_last;
  logic [IND_WIDTH-1:0] out_x, out_y;
  logic [BW-1:0]        out_strength;
  logic [DW-1:0]        out_desc;
  logic [FCW-1:0]       out_frame;
  logic [CW-1:0]        out_count;
  logic [15:0]          out_dropped;
  logic [7:0]           overrun_cnt;

  always #5 clk = ~clk;

  feature_frame_packer #(.MAX_FEAT(MAXF), .FCW(FCW), .MODE(KEEP_STRONGEST)) dut (
    .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_strength(in_strength), .in_desc(in_desc),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .out_x(out_x), .out_y(out_y), .out_strength(out_strength), .out_desc(out_desc),
    .out_frame(out_frame), .out_count(out_count), .out_dropped(out_dropped),
    .overrun_cnt(overrun_cnt)
  );

  int n_cmp = 0, n_bad = 0;
  int valid_seen = 0;
  vec_t vecs [6];
  int got_n, got_tag, got_cnt, got_drop;
  logic got_done;
  int got_s [8], got_x [8], got_y [8];
  logic got_f [8], got_l [8];
  logic [DW-1:0] got_d [8];
  int exp_s [8], exp_x [8];
  int base;

  always @(negedge clk) if (out_valid) valid_seen++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_feat(input int idx, input int s);
    in_valid    = 1'b1;
    in_x        = IND_WIDTH'(idx);
    in_y        = IND_WIDTH'(idx + 100);
    in_strength = BW'(s);
    in_desc     = {16{BW'(s)}};
  endtask

  task automatic send_feat(input int idx, input int s);
    set_feat(idx, s);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic drain(input int budget);
    got_n = 0;
    got_done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && !got_done; c++) begin
      if (out_valid) begin
        if (got_n == 0) begin
          got_tag  = int'(out_frame);
          got_cnt  = int'(out_count);
          got_drop = int'(out_dropped);
        end
        if (got_n < 8) begin
          got_s[got_n] = int'(out_strength);
          got_x[got_n] = int'(out_x);
          got_y[got_n] = int'(out_y);
          got_f[got_n] = out_first;
          got_l[got_n] = out_last;
          got_d[got_n] = out_desc;
        end
        got_n++;
        if (out_last) got_done = 1'b1;
      end
      tick();
    end
  endtask

  task automatic expect_frame(input int n, input int offs, input int tag, input int cnt, input int drop);
    check("drain_done", int'(got_done), 1);
    check("beats", got_n, n);
    check("tag", got_tag, tag);
    check("count", got_cnt, cnt);
    check("dropped", got_drop, drop);
    for (int k = 0; k < n && k < got_n; k++) begin
      check("strength", got_s[k], exp_s[k]);
      check("x", got_x[k], exp_x[k]);
      check("y", got_y[k], exp_x[k] + 100);
      check("first", int'(got_f[k]), int'(k + offs == 0));
      check("last", int'(got_l[k]), int'(k == n - 1));
      check("desc", int'(got_d[k] == {16{BW'(exp_s[k])}}), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6, '{10, 50, 30, 20, 40, 5, 0, 0, 0},   4, '{40, 50, 30, 20},   '{4, 1, 2, 3}, 2};
    vecs[1] = '{3, '{7, 8, 9, 0, 0, 0, 0, 0, 0},        3, '{7, 8, 9, 0},       '{0, 1, 2, 0}, 0};
    vecs[2] = '{6, '{5, 5, 5, 5, 6, 6, 0, 0, 0},        4, '{6, 6, 5, 5},       '{4, 5, 2, 3}, 2};
    vecs[3] = '{5, '{0, 0, 0, 0, 0, 0, 0, 0, 0},        4, '{0, 0, 0, 0},       '{0, 1, 2, 3}, 1};
    vecs[4] = '{9, '{1, 2, 3, 4, 5, 6, 7, 8, 9},        4, '{9, 6, 7, 8},       '{8, 5, 6, 7}, 5};
    vecs[5] = '{6, '{255, 254, 0, 1, 255, 3, 0, 0, 0},  4, '{255, 254, 255, 3}, '{0, 1, 4, 5}, 2};

    #12;
    check("rst_valid", int'(out_valid), 0);
    check("rst_frame", int'(out_frame), 0);
    check("rst_count", int'(out_count), 0);
    check("rst_dropped", int'(out_dropped), 0);
    check("rst_overrun", int'(overrun_cnt), 0);
    rst_n = 1'b1;
    tick();

    // pre-sync features are discarded; first boundary after sync is empty
    base = valid_seen;
    for (int i = 0; i < 5; i++) send_feat(i, 100 + i);
    pulse();
    pulse();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("presync_beats", valid_seen - base, 0);
    check("presync_overrun", int'(overrun_cnt), 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n_in; i++) send_feat(i, vecs[v].s_in[i]);
      pulse();
      check("lat_t0", int'(out_valid), 0);
      tick();
      check("lat_t1", int'(out_valid), 1);
      drain(20);
      for (int k = 0; k < 4; k++) begin
        exp_s[k] = vecs[v].s_exp[k];
        exp_x[k] = vecs[v].x_exp[k];
      end
      expect_frame(vecs[v].n_exp, 0, v + 1, vecs[v].n_exp, vecs[v].drop);
    end

    // backpressure on beat 1 for three cycles
    for (int i = 0; i < 4; i++) send_feat(i, 11 + i);
    out_ready = 1'b1;
    pulse();
    tick();
    tick();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("bp_valid", int'(out_valid), 1);
      check("bp_strength", int'(out_strength), 12);
      check("bp_x", int'(out_x), 1);
      check("bp_first", int'(out_first), 0);
    end
    drain(20);
    exp_s[0] = 12; exp_s[1] = 13; exp_s[2] = 14;
    exp_x[0] = 1;  exp_x[1] = 2;  exp_x[2] = 3;
    expect_frame(3, 1, 7, 4, 0);

    // overrun while the drain is stalled
    for (int i = 0; i < 3; i++) send_feat(i, 21 + i);
    out_ready = 1'b0;
    pulse();
    tick();
    send_feat(0, 31);
    send_feat(1, 32);
    pulse();
    check("ovr_cnt", int'(overrun_cnt), 1);
    check("ovr_valid", int'(out_valid), 1);
    check("ovr_frame", int'(out_frame), 8);
    check("ovr_strength", int'(out_strength), 21);
    drain(20);
    exp_s[0] = 21; exp_s[1] = 22; exp_s[2] = 23;
    exp_x[0] = 0;  exp_x[1] = 1;  exp_x[2] = 2;
    expect_frame(3, 0, 8, 3, 0);
    send_feat(0, 41);
    pulse();
    drain(20);
    exp_s[0] = 41; exp_x[0] = 0;
    expect_frame(1, 0, 10, 1, 0);

    // feature with boundary, and boundary with final handshake
    send_feat(0, 61);
    send_feat(1, 62);
    set_feat(0, 77);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("co_lat", int'(out_valid), 0);
    set_feat(1, 78);
    tick();
    in_valid = 1'b0;
    check("co_b0_str", int'(out_strength), 61);
    check("co_b0_first", int'(out_first), 1);
    check("co_b0_frame", int'(out_frame), 11);
    tick();
    check("co_b1_str", int'(out_strength), 62);
    check("co_b1_last", int'(out_last), 1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("co_swap_valid", int'(out_valid), 0);
    check("co_overrun", int'(overrun_cnt), 1);
    drain(20);
    exp_s[0] = 77; exp_s[1] = 78;
    exp_x[0] = 0;  exp_x[1] = 1;
    expect_frame(2, 0, 12, 2, 0);

    // async reset during beat 2
    for (int i = 0; i < 4; i++) send_feat(i, 91 + i);
    out_ready = 1'b1;
    pulse();
    tick();
    tick();
    tick();
    check("rm_b2_str", int'(out_strength), 93);
    rst_n = 1'b0;
    #1;
    check("rm_valid", int'(out_valid), 0);
    check("rm_first", int'(out_first), 0);
    check("rm_last", int'(out_last), 0);
    check("rm_x", int'(out_x), 0);
    check("rm_strength", int'(out_strength), 0);
    check("rm_frame", int'(out_frame), 0);
    check("rm_count", int'(out_count), 0);
    check("rm_dropped", int'(out_dropped), 0);
    check("rm_overrun", int'(overrun_cnt), 0);
    #2;
    rst_n = 1'b1;
    tick();
    base = valid_seen;
    send_feat(0, 33);
    pulse();
    send_feat(0, 55);
    tick();
    check("rm_no_beats", valid_seen - base, 0);
    pulse();
    check("rm_lat", int'(out_valid), 0);
    drain(20);
    exp_s[0] = 55; exp_x[0] = 0;
    expect_frame(1, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
